// File: rtl/if_pc_unit_pkg.sv
// Shared types and defaults for the IF-stage program-counter unit.
// Optional bound/alignment checking is enabled by IF_PC_BOUND_CHECK_EN.
package if_pkg;

    // Run-control states; the encoding is visible on o_state for debug readout.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STEP_WAIT = 2'd2,
        ST_HALTED    = 2'd3
    } pc_state_e;

    localparam int DEF_PC_STEP  = 4;
    localparam int DEF_RESET_PC = 0;

endpackage

// File: rtl/if_pc_unit_if.sv
// Control/redirect bundle between the pipeline, the debug unit and the PC unit.
// The slave side is the PC unit; the master side is whoever drives fetch control.
interface if_pc_unit_if #(
    parameter int PC_W = 32
);
    logic            i_start;
    logic            i_mode_step;
    logic            i_step;
    logic            i_stall;
    logic            i_branch_taken;
    logic [PC_W-1:0] i_branch_target;
    logic            i_jump;
    logic [PC_W-1:0] i_jump_target;
    logic            i_halt;
    logic [PC_W-1:0] o_pc;
    logic [PC_W-1:0] o_pc_seq;
    logic            o_valid;
    logic            o_halted;
    logic [1:0]      o_state;
    logic            o_fault;

    modport master (
        output i_start, i_mode_step, i_step, i_stall,
               i_branch_taken, i_branch_target, i_jump, i_jump_target, i_halt,
        input  o_pc, o_pc_seq, o_valid, o_halted, o_state, o_fault
    );

    modport slave (
        input  i_start, i_mode_step, i_step, i_stall,
               i_branch_taken, i_branch_target, i_jump, i_jump_target, i_halt,
        output o_pc, o_pc_seq, o_valid, o_halted, o_state, o_fault
    );
endinterface

// File: rtl/if_pc_adder.sv
// Sequential next-PC adder: o_sum = i_a + PC_STEP, wrapping modulo 2^PC_W.
module if_pc_adder
    import if_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int PC_STEP = DEF_PC_STEP
) (
    input  logic [PC_W-1:0] i_a,
    output logic [PC_W-1:0] o_sum
);

    localparam logic [PC_W-1:0] STEP_V = PC_W'(PC_STEP);

    // Carry out of the top bit is dropped so the wrap to zero is silent.
    assign o_sum = i_a + STEP_V;

endmodule

// File: rtl/if_pc_unit.sv
// IF-stage program-counter unit: PC register, next-PC priority mux and a
// run-control FSM (idle / continuous run / single-step / halted).
// Define IF_PC_BOUND_CHECK_EN to fault on misaligned or out-of-memory next PCs.
module if_pc_unit
    import if_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter int              PC_STEP    = DEF_PC_STEP,
    parameter logic [PC_W-1:0] RESET_PC   = PC_W'(DEF_RESET_PC),
    parameter int              IMEM_DEPTH = 256
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    if_pc_unit_if.slave  pc_bus
);

    localparam logic [1:0] S_IDLE      = ST_IDLE;
    localparam logic [1:0] S_RUN       = ST_RUN;
    localparam logic [1:0] S_STEP_WAIT = ST_STEP_WAIT;
    localparam logic [1:0] S_HALTED    = ST_HALTED;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pc_seq;
    logic [PC_W-1:0] w_pc_cand;
    logic            w_advance;
    logic            w_update;
    logic            w_fault_hit;

    if_pc_adder #(
        .PC_W    (PC_W),
        .PC_STEP (PC_STEP)
    ) u_adder (
        .i_a   (r_pc),
        .o_sum (w_pc_seq)
    );

    // A cycle advances (is a live fetch) in RUN, or in STEP_WAIT while i_step is high.
    assign w_advance = (r_state == S_RUN) | ((r_state == S_STEP_WAIT) & pc_bus.i_step);

    // Candidate next PC: redirects beat stall so a flush is never lost.
    always_comb begin
        w_update  = 1'b1;
        w_pc_cand = w_pc_seq;
        if (pc_bus.i_branch_taken) begin
            w_pc_cand = pc_bus.i_branch_target;
        end else if (pc_bus.i_jump) begin
            w_pc_cand = pc_bus.i_jump_target;
        end else if (pc_bus.i_stall) begin
            w_update  = 1'b0;
            w_pc_cand = r_pc;
        end
    end

`ifdef IF_PC_BOUND_CHECK_EN
    localparam logic [PC_W-1:0] STEP_V  = PC_W'(PC_STEP);
    localparam logic [63:0]     LIMIT_V = 64'(IMEM_DEPTH) * 64'(PC_STEP);

    logic r_fault;

    // Only a PC that would actually be loaded is checked; halt takes precedence.
    assign w_fault_hit = w_advance & ~pc_bus.i_halt & w_update &
                         (((w_pc_cand % STEP_V) != '0) | (64'(w_pc_cand) >= LIMIT_V));

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fault <= 1'b0;
        end else if (w_fault_hit) begin
            r_fault <= 1'b1;
        end
    end

    assign pc_bus.o_fault = r_fault;
`else
    assign w_fault_hit = 1'b0;
    // Constant 0 for any legal depth; the reference keeps IMEM_DEPTH live in this build.
    assign pc_bus.o_fault = (IMEM_DEPTH < 0);
`endif

    // Next state and next PC for the run-control FSM.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            S_IDLE: begin
                if (pc_bus.i_start) begin
                    w_pc_next    = RESET_PC;
                    w_state_next = pc_bus.i_mode_step ? S_STEP_WAIT : S_RUN;
                end
            end
            S_RUN, S_STEP_WAIT: begin
                if (w_advance) begin
                    if (pc_bus.i_halt || w_fault_hit) begin
                        w_state_next = S_HALTED;
                    end else if (w_update) begin
                        w_pc_next = w_pc_cand;
                    end
                end
            end
            default: begin
                // HALTED: frozen until reset, i_start ignored.
                w_state_next = S_HALTED;
            end
        endcase
    end

    // State and PC registers; reset aborts any run without keeping a redirect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    assign pc_bus.o_pc     = r_pc;
    assign pc_bus.o_pc_seq = w_pc_seq;
    assign pc_bus.o_valid  = w_advance;
    assign pc_bus.o_halted = (r_state == S_HALTED);
    assign pc_bus.o_state  = r_state;

endmodule

// File: doc/if_pc_unit.md
Name: if_pc_unit

Overview:
Program-counter unit for the IF stage of the pipelined processor.
- Holds the PC register and generates the sequential next PC (PC + step), parametrised in width and step.
- Arbitrates branch/jump redirects and stalls.
- Adds a run-control FSM for continuous and single-step execution driven by the debug unit.

Parameters:
PC_W, 32, PC and target width in bits
PC_STEP, 4, increment applied per fetch (bytes)
RESET_PC, 0, PC value loaded at reset and on i_start
IMEM_DEPTH, 256, instruction-memory depth in words (used only by the optional bound check)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  pulse; IDLE -> RUN/STEP, loads RESET_PC
i_mode_step  in  1  sampled with i_start; 1 = single-step mode, 0 = continuous
i_step  in  1  pulse; in step mode, advances exactly one fetch
i_stall  in  1  hazard stall from ID; hold PC
i_branch_taken  in  1  redirect from EX
i_branch_target  in  PC_W  branch destination
i_jump  in  1  redirect from ID
i_jump_target  in  PC_W  jump destination
i_halt  in  1  HALT opcode decoded; stop fetching
o_pc  out  PC_W  current fetch address
o_pc_seq  out  PC_W  o_pc + PC_STEP (combinational, to the IF/ID latch)
o_valid  out  1  o_pc is a live fetch this cycle
o_halted  out  1  FSM in HALTED
o_state  out  2  FSM state encoding, for debug readout
o_fault  out  1  bound/alignment fault (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async, i_rst_n=0): o_pc=RESET_PC, state=IDLE, o_valid=0, o_halted=0, o_fault=0. Reset mid-run aborts immediately; no pending redirect is retained.
- States:
  - IDLE=0: o_valid=0, PC frozen. i_start -> RUN if i_mode_step=0, else STEP_WAIT. o_pc<=RESET_PC.
  - RUN=1: o_valid=1. PC updates every cycle per priority.
  - STEP_WAIT=2: o_valid=0, PC frozen until i_step. On i_step, a one-cycle advance occurs with o_valid=1 in that cycle, then the FSM returns to STEP_WAIT.
  - HALTED=3: o_valid=0, o_halted=1, PC frozen. Only reset exits; i_start is ignored.
- Next-PC priority, evaluated in any advancing cycle (RUN, or STEP_WAIT with i_step), highest first:
  1. i_halt: PC holds, -> HALTED next cycle.
  2. i_branch_taken: PC <= i_branch_target.
  3. i_jump: PC <= i_jump_target.
  4. i_stall: PC holds.
  5. Otherwise: PC <= o_pc_seq.
- Redirects override i_stall, so a flush is never lost.
- i_halt coincident with i_branch_taken: halt wins. The PC is not updated.
- In a non-advancing cycle, redirects and stall are ignored. Upstream stages hold these signals until o_valid.
- Arithmetic:
  - o_pc_seq = (o_pc + PC_STEP) mod 2^PC_W.
  - Wrap from 2^PC_W-PC_STEP to 0 is legal and silent.
  - Targets are taken unmodified.
- Latency: a redirect asserted in cycle N appears on o_pc in cycle N+1.

Optional Feature:
IF_PC_BOUND_CHECK_EN
- Defined: any next-PC value that is not a multiple of PC_STEP, or is >= IMEM_DEPTH*PC_STEP, triggers a fault:
  - o_fault set (sticky until reset).
  - PC holds its old value.
  - FSM -> HALTED next cycle.
- Undefined: o_fault tied 0, no checking, no extra logic.

Decomposition:
- Package if_pkg: state enum (IDLE, RUN, STEP_WAIT, HALTED) with 2-bit encoding, default PC_STEP and RESET_PC constants.
- Sub-module if_pc_adder: parametrised combinational PC_W-bit adder (a + PC_STEP), instantiated once for o_pc_seq.
- FSM and PC register stay in if_pc_unit.

Test Plan:
- Reset then i_start, i_mode_step=0, 4 free cycles -> o_pc 0x0, 0x4, 0x8, 0xC; o_valid=1 from the first RUN cycle.
- In RUN at o_pc=0x10: i_stall 2 cycles, then i_jump with target 0x40 while i_stall=1 -> PC holds 0x10 two cycles, then 0x40.
- i_branch_taken target 0x80 and i_jump target 0x40 in the same cycle -> next o_pc=0x80. i_halt together with a branch -> PC holds, o_halted=1 next cycle; later i_start has no effect.
- Step mode: i_start with i_mode_step=1, three i_step pulses spaced 5 cycles -> o_pc 0x0 -> 0x4 -> 0x8 -> 0xC; o_valid high only in the three step cycles.
- PC_W=8, jump to 0xFC, free-run -> o_pc 0xFC then 0x00. Assert i_rst_n=0 mid-run -> o_pc=RESET_PC immediately and state IDLE.
- With IF_PC_BOUND_CHECK_EN, IMEM_DEPTH=256: jump to 0x402 -> o_fault=1, PC holds, HALTED. Without the macro, same stimulus -> o_pc=0x402, o_fault=0.
